// File: rtl/vga_dac.sv
// rtl/vga_dac.sv - 256x12 VGA palette DAC with CPU port interface
//
// Ports:
//   clock, reset     system clock, synchronous active-high reset
//   port_a[15:0]     CPU I/O address (3C7h read index/state, 3C8h write index, 3C9h data)
//   port_o[7:0]      CPU write data
//   port_w, port_r   single-cycle I/O write / read strobes
//   port_i[7:0]      combinational read data returned to the CPU
//   dac_a[7:0]       palette index from the video block
//   dac_q[11:0]      combinational {R4,G4,B4} of entry dac_a
module vga_dac (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] port_a,
  input  logic [7:0]  port_o,
  input  logic        port_w,
  input  logic        port_r,
  output logic [7:0]  port_i,
  input  logic [7:0]  dac_a,
  output logic [11:0] dac_q
);

  localparam logic [15:0] ADDR_RD_IDX = 16'h03C7;
  localparam logic [15:0] ADDR_WR_IDX = 16'h03C8;
  localparam logic [15:0] ADDR_DATA   = 16'h03C9;

  typedef enum logic [1:0] {PH_R, PH_G, PH_B} phase_t;
  typedef enum logic {MODE_WRITE, MODE_READ} mode_t;

  // Palette storage; power-up image is the 16-colour CGA set, rest black.
  // Reset deliberately leaves this array alone.
  logic [11:0] pal [0:255] = '{
    0: 12'h000,  1: 12'h00A,  2: 12'h0A0,  3: 12'h0AA,
    4: 12'hA00,  5: 12'hA0A,  6: 12'hA50,  7: 12'hAAA,
    8: 12'h555,  9: 12'h55F, 10: 12'h5F5, 11: 12'h5FF,
    12: 12'hF55, 13: 12'hF5F, 14: 12'hFF5, 15: 12'hFFF,
    default: 12'h000
  };

  phase_t     wr_phase, wr_phase_nxt;
  phase_t     rd_phase, rd_phase_nxt;
  mode_t      mode, mode_nxt;
  logic [7:0] wr_idx, wr_idx_nxt;
  logic [7:0] rd_idx, rd_idx_nxt;
  logic [3:0] tmp_r, tmp_r_nxt;
  logic [3:0] tmp_g, tmp_g_nxt;
  logic       commit;
  logic [11:0] rd_entry;
  logic [3:0]  rd_comp;

  logic sel_rd_idx, sel_wr_idx, sel_data;
  assign sel_rd_idx = (port_a == ADDR_RD_IDX);
  assign sel_wr_idx = (port_a == ADDR_WR_IDX);
  assign sel_data   = (port_a == ADDR_DATA);

  // Asynchronous read port: old contents are visible during a commit cycle.
  assign dac_q    = pal[dac_a];
  assign rd_entry = pal[rd_idx];

  // Next-state logic for both component sequencers. A write strobe takes
  // priority, so a simultaneous read has no side effects.
  always_comb begin
    wr_phase_nxt = wr_phase;
    rd_phase_nxt = rd_phase;
    mode_nxt     = mode;
    wr_idx_nxt   = wr_idx;
    rd_idx_nxt   = rd_idx;
    tmp_r_nxt    = tmp_r;
    tmp_g_nxt    = tmp_g;
    commit       = 1'b0;
    if (port_w) begin
      if (sel_wr_idx) begin
        wr_idx_nxt   = port_o;
        wr_phase_nxt = PH_R;   // drops any partial triplet
        mode_nxt     = MODE_WRITE;
      end else if (sel_rd_idx) begin
        rd_idx_nxt   = port_o;
        rd_phase_nxt = PH_R;
        mode_nxt     = MODE_READ;
      end else if (sel_data && mode == MODE_WRITE) begin
        case (wr_phase)
          PH_R: begin
            tmp_r_nxt    = port_o[5:2];
            wr_phase_nxt = PH_G;
          end
          PH_G: begin
            tmp_g_nxt    = port_o[5:2];
            wr_phase_nxt = PH_B;
          end
          PH_B: begin
            commit       = 1'b1;
            wr_idx_nxt   = wr_idx + 8'd1;
            wr_phase_nxt = PH_R;
          end
          default: wr_phase_nxt = PH_R;
        endcase
      end
    end else if (port_r && sel_data && mode == MODE_READ) begin
      case (rd_phase)
        PH_R: rd_phase_nxt = PH_G;
        PH_G: rd_phase_nxt = PH_B;
        PH_B: begin
          rd_phase_nxt = PH_R;
          rd_idx_nxt   = rd_idx + 8'd1;
        end
        default: rd_phase_nxt = PH_R;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_phase <= PH_R;
      rd_phase <= PH_R;
      mode     <= MODE_WRITE;
      wr_idx   <= 8'h00;
      rd_idx   <= 8'h00;
      tmp_r    <= 4'h0;
      tmp_g    <= 4'h0;
    end else begin
      wr_phase <= wr_phase_nxt;
      rd_phase <= rd_phase_nxt;
      mode     <= mode_nxt;
      wr_idx   <= wr_idx_nxt;
      rd_idx   <= rd_idx_nxt;
      tmp_r    <= tmp_r_nxt;
      tmp_g    <= tmp_g_nxt;
    end
  end

  // Gating on reset aborts a triplet whose final write coincides with reset.
  always_ff @(posedge clock) begin
    if (!reset && commit) begin
      pal[wr_idx] <= {tmp_r, tmp_g, port_o[5:2]};
    end
  end

  always_comb begin
    case (rd_phase)
      PH_R:    rd_comp = rd_entry[11:8];
      PH_G:    rd_comp = rd_entry[7:4];
      default: rd_comp = rd_entry[3:0];
    endcase
  end

  always_comb begin
    port_i = 8'h00;
    if (sel_rd_idx) begin
      port_i = (mode == MODE_READ) ? 8'h03 : 8'h00;
    end else if (sel_wr_idx) begin
      port_i = wr_idx;
    end else if (sel_data) begin
      port_i = {2'b00, rd_comp, 2'b00};
    end
  end

endmodule

// File: tb/tb_vga_dac.sv
// tb/tb_vga_dac.sv - self-checking bench for vga_dac
module tb_vga_dac;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] port_a = 16'h0000;
  logic [7:0]  port_o = 8'h00;
  logic        port_w = 1'b0;
  logic        port_r = 1'b0;
  logic [7:0]  port_i;
  logic [7:0]  dac_a = 8'h00;
  logic [11:0] dac_q;

  int checks = 0;
  int errors = 0;

  vga_dac dut (
    .clock  (clock),
    .reset  (reset),
    .port_a (port_a),
    .port_o (port_o),
    .port_w (port_w),
    .port_r (port_r),
    .port_i (port_i),
    .dac_a  (dac_a),
    .dac_q  (dac_q)
  );

  always #5 clock = ~clock;

  // Reference model: palette array, pending components held in a queue,
  // read position counted as 0..2 within the current entry.
  logic [11:0] m_pal [256];
  logic [3:0]  wq [$];
  logic [7:0]  m_wr_idx;
  logic [7:0]  m_rd_idx;
  int          m_rd_cnt;
  bit          m_read;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    wq.delete();
    m_wr_idx = 8'h00;
    m_rd_idx = 8'h00;
    m_rd_cnt = 0;
    m_read   = 1'b0;
  endtask

  function automatic logic [7:0] model_port_i(input logic [15:0] a);
    logic [11:0] e;
    logic [11:0] c;
    if (a == 16'h03C7) return m_read ? 8'h03 : 8'h00;
    if (a == 16'h03C8) return m_wr_idx;
    if (a == 16'h03C9) begin
      e = m_pal[m_rd_idx];
      c = (e >> (4 * (2 - m_rd_cnt))) & 12'h00F;
      return {2'b00, c[3:0], 2'b00};
    end
    return 8'h00;
  endfunction

  task automatic model_apply(input logic [15:0] a, input logic [7:0] o, input bit w, input bit r);
    if (w) begin
      if (a == 16'h03C8) begin
        m_wr_idx = o;
        wq.delete();
        m_read = 1'b0;
      end else if (a == 16'h03C7) begin
        m_rd_idx = o;
        m_rd_cnt = 0;
        m_read   = 1'b1;
      end else if (a == 16'h03C9 && !m_read) begin
        wq.push_back(o[5:2]);
        if (wq.size() == 3) begin
          m_pal[m_wr_idx] = {wq[0], wq[1], wq[2]};
          m_wr_idx = m_wr_idx + 8'd1;
          wq.delete();
        end
      end
    end else if (r && a == 16'h03C9 && m_read) begin
      m_rd_cnt++;
      if (m_rd_cnt == 3) begin
        m_rd_cnt = 0;
        m_rd_idx = m_rd_idx + 8'd1;
      end
    end
  endtask

  // One bus cycle: outputs are checked mid-cycle, the model advances at the edge.
  task automatic bus(input logic [15:0] a, input logic [7:0] o, input bit w, input bit r);
    port_a = a;
    port_o = o;
    port_w = w;
    port_r = r;
    #2;
    check("bus_port_i", {8'h00, port_i}, {8'h00, model_port_i(a)});
    check("bus_dac_q", {4'h0, dac_q}, {4'h0, m_pal[dac_a]});
    @(posedge clock);
    model_apply(a, o, w, r);
    #1;
    port_w = 1'b0;
    port_r = 1'b0;
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] o);
    bus(a, o, 1'b1, 1'b0);
  endtask

  task automatic rd(input logic [15:0] a);
    bus(a, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) @(posedge clock);
    model_reset();
    #1;
    reset = 1'b0;
  endtask

  task automatic peek(input string tag, input logic [7:0] idx, input logic [11:0] exp);
    dac_a = idx;
    #1;
    check(tag, {4'h0, dac_q}, {4'h0, exp});
  endtask

  task automatic probe(input string tag, input logic [15:0] a, input logic [7:0] exp);
    port_a = a;
    #1;
    check(tag, {8'h00, port_i}, {8'h00, exp});
  endtask

  initial begin
    logic [11:0] cga [16];
    logic [7:0]  ro;
    logic [15:0] ra;
    int          op;

    cga = '{12'h000, 12'h00A, 12'h0A0, 12'h0AA, 12'hA00, 12'hA0A, 12'hA50, 12'hAAA,
            12'h555, 12'h55F, 12'h5F5, 12'h5FF, 12'hF55, 12'hF5F, 12'hFF5, 12'hFFF};
    for (int i = 0; i < 256; i++) m_pal[i] = (i < 16) ? cga[i] : 12'h000;
    model_reset();

    do_reset(2);

    probe("rst_state_3c7", 16'h03C7, 8'h00);
    probe("rst_wr_idx_3c8", 16'h03C8, 8'h00);
    probe("rst_data_3c9", 16'h03C9, 8'h00);
    peek("init_07", 8'h07, 12'hAAA);
    peek("init_0f", 8'h0F, 12'hFFF);
    peek("init_20", 8'h20, 12'h000);
    peek("init_06", 8'h06, 12'hA50);
    peek("init_01", 8'h01, 12'h00A);
    probe("undecoded_13c9", 16'h13C9, 8'h00);
    probe("undecoded_03c6", 16'h03C6, 8'h00);

    // Simple triplet write
    wr(16'h03C8, 8'h05);
    wr(16'h03C9, 8'h3F);
    wr(16'h03C9, 8'h00);
    wr(16'h03C9, 8'h2A);
    peek("entry05_f0a", 8'h05, 12'hF0A);
    probe("wr_idx_06", 16'h03C8, 8'h06);

    // Write index wrap FFh -> 00h
    wr(16'h03C8, 8'hFF);
    repeat (3) wr(16'h03C9, 8'h3F);
    repeat (3) wr(16'h03C9, 8'h04);
    peek("entryff_fff", 8'hFF, 12'hFFF);
    peek("entry00_111", 8'h00, 12'h111);
    probe("wr_idx_wrap_01", 16'h03C8, 8'h01);

    // Read sequence from entry 0Eh
    wr(16'h03C7, 8'h0E);
    probe("rd_0e_r", 16'h03C9, 8'h3C);
    rd(16'h03C9);
    probe("rd_0e_g", 16'h03C9, 8'h3C);
    rd(16'h03C9);
    probe("rd_0e_b", 16'h03C9, 8'h14);
    rd(16'h03C9);
    probe("rd_idx_0f_r", 16'h03C9, 8'h3C);
    probe("read_mode_3c7", 16'h03C7, 8'h03);

    // Reset mid-triplet aborts it
    wr(16'h03C8, 8'h01);
    wr(16'h03C9, 8'h3F);
    wr(16'h03C9, 8'h3F);
    do_reset(1);
    repeat (3) wr(16'h03C9, 8'h3F);
    peek("abort_entry01", 8'h01, 12'h00A);
    peek("after_rst_entry00", 8'h00, 12'hFFF);

    // Commit with dac_a on the same entry: old value, then new value
    wr(16'h03C8, 8'h05);
    wr(16'h03C9, 8'h04);
    wr(16'h03C9, 8'h08);
    peek("commit_cycle_old", 8'h05, 12'hF0A);
    wr(16'h03C9, 8'h0C);
    peek("commit_next_new", 8'h05, 12'h123);

    // Simultaneous read/write strobes: read side effects suppressed
    wr(16'h03C7, 8'h05);
    probe("dual_before", 16'h03C9, 8'h04);
    bus(16'h03C9, 8'h3F, 1'b1, 1'b1);
    probe("dual_no_advance", 16'h03C9, 8'h04);
    rd(16'h03C9);
    probe("dual_then_read", 16'h03C9, 8'h08);
    peek("dual_no_write", 8'h05, 12'h123);

    // Partial triplet discarded by a new write index
    wr(16'h03C8, 8'h30);
    wr(16'h03C9, 8'h3F);
    wr(16'h03C9, 8'h3F);
    wr(16'h03C8, 8'h31);
    repeat (3) wr(16'h03C9, 8'h3F);
    peek("partial_entry30", 8'h30, 12'h000);
    peek("full_entry31", 8'h31, 12'hFFF);

    // Read index wrap FFh -> 00h
    wr(16'h03C7, 8'hFF);
    repeat (3) rd(16'h03C9);
    wr(16'h03C8, 8'h00);
    probe("rd_wrap_state_write", 16'h03C7, 8'h00);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      dac_a = 8'($urandom);
      ro = ($urandom_range(0, 3) == 0) ? (8'hFE + 8'($urandom_range(0, 1))) : 8'($urandom);
      op = $urandom_range(0, 10);
      case (op)
        0:          wr(16'h03C8, ro);
        1:          wr(16'h03C7, ro);
        2, 3, 4:    wr(16'h03C9, ro);
        5, 6:       rd(16'h03C9);
        7:          rd(($urandom_range(0, 1) == 0) ? 16'h03C7 : 16'h03C8);
        8:          bus(16'h03C9, ro, 1'b1, 1'b1);
        9: begin
          ra = 16'($urandom);
          if (ra >= 16'h03C7 && ra <= 16'h03C9) ra = ra ^ 16'h8000;
          rd(ra);
        end
        default: begin
          if ($urandom_range(0, 4) == 0) do_reset(1);
          else wr(16'h03C9, ro);
        end
      endcase
    end

    // Full palette sweep
    for (int i = 0; i < 256; i++) begin
      dac_a = 8'(i);
      #1;
      check("sweep_dac_q", {4'h0, dac_q}, {4'h0, m_pal[i]});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_dac.md
VGA_DAC -- requirements
Module: vga_dac

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset; all state SHALL change only on the rising edge of clock.
REQ-002 clock  input  1  system clock, shared with the video scan-out block.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 port_a  input  16  CPU I/O port address.
REQ-005 port_o  input  8  CPU data out (write data).
REQ-006 port_w  input  1  I/O write strobe, one cycle per access.
REQ-007 port_r  input  1  I/O read strobe, one cycle per access.
REQ-008 port_i  output  8  data returned to CPU.
REQ-009 dac_a  input  8  palette index from the video block.
REQ-010 dac_q  output  12  {R4,G4,B4} colour of entry dac_a.

Function
REQ-011 Storage SHALL be 256 entries x 12 bits, {R[3:0],G[3:0],B[3:0]}.
REQ-012 dac_q SHALL be a combinational (asynchronous) read of entry dac_a, valid in the same cycle dac_a is presented; the video block samples it one cycle after driving dac_a.
REQ-013 Decoded ports: 3C7h write sets rd_idx; 3C8h write sets wr_idx; 3C9h write/read is a data access; 3C7h read returns state; 3C8h read returns wr_idx.
REQ-014 Writing 3C8h SHALL load wr_idx <= port_o and clear wr_phase to 0.
REQ-015 Writing 3C7h SHALL load rd_idx <= port_o, clear rd_phase to 0, and set mode to READ.
REQ-016 Writing 3C8h SHALL set mode to WRITE.
REQ-017 Each 6-bit component write SHALL be truncated to port_o[5:2]; port_o[7:6] are ignored.
REQ-018 Write FSM states: PH_R, PH_G, PH_B.
REQ-019 PH_R SHALL latch tmp_r and advance to PH_G.
REQ-020 PH_G SHALL latch tmp_g and advance to PH_B.
REQ-021 PH_B SHALL write {tmp_r,tmp_g,port_o[5:2]} to entry wr_idx, increment wr_idx modulo 256, and return to PH_R.
REQ-022 Read FSM states: PH_R, PH_G, PH_B, with the same sequencing as the write FSM.
REQ-023 In state X, port_i on a 3C9h read SHALL be {2'b00, comp[3:0], 2'b00} of entry rd_idx.
REQ-024 A port_r pulse at 3C9h SHALL advance rd_phase; after PH_B it SHALL increment rd_idx modulo 256.
REQ-025 port_i SHALL be combinational from the current state and port_a; it SHALL read 00h for undecoded addresses.
REQ-026 3C7h read SHALL return 03h in READ mode and 00h in WRITE mode.
REQ-027 Boundary: wr_idx or rd_idx at FFh followed by a triplet completion SHALL wrap to 00h.
REQ-028 Boundary: a commit to entry N in the same cycle that dac_a = N SHALL show the old value on dac_q in that cycle and the new value from the next cycle.
REQ-029 Boundary: port_w and port_r asserted in the same cycle SHALL perform the write only; the read side effects are suppressed.
REQ-030 Boundary: a partial triplet (1 or 2 components written) followed by a 3C8h write SHALL be discarded with no entry modified.
REQ-031 Write and read FSMs SHALL be independent; a data access advances only the FSM of the current mode.

Reset
REQ-032 Reset SHALL set wr_idx = 0, rd_idx = 0, wr_phase = rd_phase = PH_R, mode = WRITE, and tmp_r = tmp_g = 0.
REQ-033 Reset SHALL NOT alter palette contents.
REQ-034 Power-up contents SHALL be: entries 0-15 hold the CGA palette (0=000, 1=00A, 6=A50, 7=AAA, 14=FF5, 15=FFF, others per standard); entries 16-255 = 000.
REQ-035 Reset asserted mid-triplet SHALL abort the triplet with no entry written.

Verification
REQ-036 After reset, dac_a=07h -> dac_q=AAAh in the same cycle; dac_a=0Fh -> FFFh; dac_a=20h -> 000h.
REQ-037 Write 3C8h=05h, then 3C9h=3Fh,00h,2Ah -> entry 05h = F0Ah, wr_idx=06h, 3C8h read returns 06h.
REQ-038 Write 3C8h=FFh, then six 3C9h writes (3Fh x3, 04h x3) -> entry FFh = FFFh, entry 00h = 111h, wr_idx=01h.
REQ-039 Write 3C7h=0Eh, read 3C9h x3 -> 3Ch,3Ch,14h; rd_idx=0Fh; 3C7h read returns 03h.
REQ-040 Write 3C8h=01h, 3C9h=3Fh, 3C9h=3Fh, reset pulse, 3C9h=3Fh x3 -> entry 01h still 00Ah, entry 00h = FFFh.
REQ-041 With dac_a=05h, complete a triplet to entry 05h -> dac_q shows the old value in the commit cycle and the new value in the following cycle.
